// File: rtl/ld_str_multi_addr_seq_if.sv
// Request / memory-access / writeback signal bundle for the load/store address stage.
interface ld_str_multi_addr_seq_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned IMM_W   = 12,
    parameter int unsigned REG_CNT = 16,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned TAG_W   = 4
);
    // Decoded request from the issue stage
    logic               req_valid_in;
    logic               req_ready_out;
    logic [TAG_W-1:0]   req_tag_in;
    logic               req_cond_pass_in;
    logic               req_load_in;
    logic               req_multi_in;
    logic               req_pre_in;
    logic               req_up_in;
    logic               req_wb_in;
    logic               req_use_reg_in;
    logic [ADDR_W-1:0]  req_base_in;
    logic [IMM_W-1:0]   req_imm_in;
    logic [ADDR_W-1:0]  req_reg_off_in;
    logic [RADDR_W-1:0] req_rd_in;
    logic [REG_CNT-1:0] req_reg_list_in;

    // Access stream to the memory stage
    logic               acc_valid_out;
    logic               acc_ready_in;
    logic [ADDR_W-1:0]  acc_addr_out;
    logic [RADDR_W-1:0] acc_reg_out;
    logic               acc_load_out;
    logic               acc_last_out;
    logic [TAG_W-1:0]   acc_tag_out;

    // Base-register writeback and status
    logic               wb_valid_out;
    logic [ADDR_W-1:0]  wb_addr_out;
    logic [TAG_W-1:0]   wb_tag_out;
    logic               busy_out;

    // Upstream / memory-stage side
    modport master (
        output req_valid_in, req_tag_in, req_cond_pass_in, req_load_in, req_multi_in,
               req_pre_in, req_up_in, req_wb_in, req_use_reg_in, req_base_in,
               req_imm_in, req_reg_off_in, req_rd_in, req_reg_list_in, acc_ready_in,
        input  req_ready_out, acc_valid_out, acc_addr_out, acc_reg_out, acc_load_out,
               acc_last_out, acc_tag_out, wb_valid_out, wb_addr_out, wb_tag_out, busy_out
    );

    // Address-stage side
    modport slave (
        input  req_valid_in, req_tag_in, req_cond_pass_in, req_load_in, req_multi_in,
               req_pre_in, req_up_in, req_wb_in, req_use_reg_in, req_base_in,
               req_imm_in, req_reg_off_in, req_rd_in, req_reg_list_in, acc_ready_in,
        output req_ready_out, acc_valid_out, acc_addr_out, acc_reg_out, acc_load_out,
               acc_last_out, acc_tag_out, wb_valid_out, wb_addr_out, wb_tag_out, busy_out
    );
endinterface

// File: rtl/ld_str_multi_addr_seq.sv
// Load/store address stage: computes single and multiple-register effective addresses,
// sequences register lists one access per cycle, and pulses the base writeback.
module ld_str_multi_addr_seq #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned IMM_W   = 12,
    parameter int unsigned REG_CNT = 16,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned TAG_W   = 4
) (
    input logic                    clk_in,
    input logic                    reset_in,
    ld_str_multi_addr_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WB
    } state_e;

    state_e             state_q, state_d;
    logic [REG_CNT-1:0] list_q, list_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [RADDR_W-1:0] reg_q, reg_d;
    logic               load_q, load_d;
    logic               last_q, last_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               wb_need_q, wb_need_d;
    logic [ADDR_W-1:0]  wb_pend_q, wb_pend_d;
    logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;

    logic [ADDR_W-1:0]  off;
    logic [ADDR_W-1:0]  eff;
    logic [ADDR_W-1:0]  span;
    logic [ADDR_W-1:0]  multi_start;
    logic [REG_CNT-1:0] list_next;

    function automatic logic [RADDR_W-1:0] lowest_idx(input logic [REG_CNT-1:0] l);
        lowest_idx = '0;
        for (int unsigned i = REG_CNT; i > 0; i--) begin
            if (l[i-1]) lowest_idx = RADDR_W'(i - 1);
        end
    endfunction

    function automatic logic [ADDR_W-1:0] popcount(input logic [REG_CNT-1:0] l);
        popcount = '0;
        for (int unsigned i = 0; i < REG_CNT; i++) begin
            if (l[i]) popcount = popcount + ADDR_W'(1);
        end
    endfunction

    // Address arithmetic for the request currently presented (all modulo 2^ADDR_W)
    always_comb begin
        off  = bus.req_use_reg_in ? bus.req_reg_off_in : ADDR_W'(bus.req_imm_in);
        eff  = bus.req_up_in ? (bus.req_base_in + off) : (bus.req_base_in - off);
        span = popcount(bus.req_reg_list_in) << 2;
        unique case ({bus.req_pre_in, bus.req_up_in})
            2'b01:   multi_start = bus.req_base_in;                        // IA
            2'b11:   multi_start = bus.req_base_in + ADDR_W'(4);           // IB
            2'b00:   multi_start = bus.req_base_in - span + ADDR_W'(4);    // DA
            default: multi_start = bus.req_base_in - span;                 // DB
        endcase
        list_next = list_q & (list_q - REG_CNT'(1));
    end

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        addr_d    = addr_q;
        reg_d     = reg_q;
        load_d    = load_q;
        last_d    = last_q;
        tag_d     = tag_q;
        wb_need_d = wb_need_q;
        wb_pend_d = wb_pend_q;
        wb_addr_d = wb_addr_q;
        wb_tag_d  = wb_tag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_in && bus.req_cond_pass_in) begin
                    if (!bus.req_multi_in) begin
                        addr_d    = bus.req_pre_in ? eff : bus.req_base_in;
                        reg_d     = bus.req_rd_in;
                        last_d    = 1'b1;
                        wb_need_d = bus.req_wb_in | ~bus.req_pre_in;
                        wb_pend_d = eff;
                        load_d    = bus.req_load_in;
                        tag_d     = bus.req_tag_in;
                        state_d   = ST_ISSUE;
                    end else if (|bus.req_reg_list_in) begin
                        list_d    = bus.req_reg_list_in;
                        addr_d    = multi_start;
                        reg_d     = lowest_idx(bus.req_reg_list_in);
                        last_d    = (bus.req_reg_list_in &
                                     (bus.req_reg_list_in - REG_CNT'(1))) == '0;
                        wb_need_d = bus.req_wb_in;
                        wb_pend_d = bus.req_up_in ? (bus.req_base_in + span)
                                                  : (bus.req_base_in - span);
                        load_d    = bus.req_load_in;
                        tag_d     = bus.req_tag_in;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.acc_ready_in) begin
                    if (last_q) begin
                        if (wb_need_q) begin
                            // Writeback value/tag are published on entry to WB and then
                            // held until the next writeback
                            wb_addr_d = wb_pend_q;
                            wb_tag_d  = tag_q;
                            state_d   = ST_WB;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        list_d = list_next;
                        addr_d = addr_q + ADDR_W'(4);
                        reg_d  = lowest_idx(list_next);
                        last_d = (list_next & (list_next - REG_CNT'(1))) == '0;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            list_q    <= '0;
            addr_q    <= '0;
            reg_q     <= '0;
            load_q    <= 1'b0;
            last_q    <= 1'b0;
            tag_q     <= '0;
            wb_need_q <= 1'b0;
            wb_pend_q <= '0;
            wb_addr_q <= '0;
            wb_tag_q  <= '0;
        end else begin
            state_q   <= state_d;
            list_q    <= list_d;
            addr_q    <= addr_d;
            reg_q     <= reg_d;
            load_q    <= load_d;
            last_q    <= last_d;
            tag_q     <= tag_d;
            wb_need_q <= wb_need_d;
            wb_pend_q <= wb_pend_d;
            wb_addr_q <= wb_addr_d;
            wb_tag_q  <= wb_tag_d;
        end
    end

    assign bus.req_ready_out = (state_q == ST_IDLE);
    assign bus.acc_valid_out = (state_q == ST_ISSUE);
    assign bus.acc_addr_out  = addr_q;
    assign bus.acc_reg_out   = reg_q;
    assign bus.acc_load_out  = load_q;
    assign bus.acc_last_out  = last_q;
    assign bus.acc_tag_out   = tag_q;
    assign bus.wb_valid_out  = (state_q == ST_WB);
    assign bus.wb_addr_out   = wb_addr_q;
    assign bus.wb_tag_out    = wb_tag_q;
    assign bus.busy_out      = (state_q != ST_IDLE);

endmodule
